// File: rtl/iopmp_entry_scan_ram_if.sv
// Bundle for the IOPMP entry table: one register-file write port plus
// NUM_PORTS scan channels, each packed flat in port order.
interface iopmp_entry_scan_ram_if #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 32,
  parameter int NUM_PORTS  = 2
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                            wr_en;
  logic [ADDR_WIDTH-1:0]           wr_idx;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic [NUM_PORTS-1:0]            scan_start;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] scan_first;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] scan_last;
  logic [NUM_PORTS-1:0]            scan_abort;
  logic [NUM_PORTS-1:0]            busy;
  logic [NUM_PORTS-1:0]            err;
  logic [NUM_PORTS-1:0]            rd_valid;
  logic [NUM_PORTS-1:0]            rd_ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_idx;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_PORTS-1:0]            rd_last;

  modport master (
    output wr_en, wr_idx, wr_data, scan_start, scan_first, scan_last, scan_abort, rd_ready,
    input  busy, err, rd_valid, rd_idx, rd_data, rd_last
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, scan_start, scan_first, scan_last, scan_abort, rd_ready,
    output busy, err, rd_valid, rd_idx, rd_data, rd_last
  );
endinterface

// File: rtl/iopmp_entry_scan_ram.sv
// IOPMP entry table: incremental writes from the register file and NUM_PORTS
// independent scan engines streaming entries [first..last] over valid/ready.
module iopmp_entry_scan_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 32,
  parameter int NUM_PORTS  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  iopmp_entry_scan_ram_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef logic [ADDR_WIDTH-1:0] idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  word_t                           mem_r      [DEPTH];
  state_e                          state_r    [NUM_PORTS];
  idx_t                            last_idx_r [NUM_PORTS];
  logic [NUM_PORTS-1:0]            busy_r;
  logic [NUM_PORTS-1:0]            err_r;
  logic [NUM_PORTS-1:0]            valid_r;
  logic [NUM_PORTS-1:0]            rd_last_r;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_idx_r;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data_r;

  function automatic logic in_range(input idx_t idx);
    return int'(idx) < DEPTH;
  endfunction

  function automatic idx_t first_of(input int p);
    return bus.scan_first[p*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic idx_t last_of(input int p);
    return bus.scan_last[p*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic idx_t next_of(input int p);
    return rd_idx_r[p*ADDR_WIDTH +: ADDR_WIDTH] + idx_t'(1);
  endfunction

  // A write landing on the index being loaded wins over the stored word.
  function automatic word_t fetch(input idx_t idx);
    if (bus.wr_en && (bus.wr_idx == idx)) begin
      return bus.wr_data;
    end else begin
      return mem_r[idx];
    end
  endfunction

  // Entry storage: cleared by reset, one word updated per register-file write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (bus.wr_en && in_range(bus.wr_idx)) begin
      mem_r[bus.wr_idx] <= bus.wr_data;
    end
  end

  // Per-port scan engines; every output is a register loaded here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_r[p]    <= IDLE;
        last_idx_r[p] <= '0;
      end
      busy_r    <= '0;
      err_r     <= '0;
      valid_r   <= '0;
      rd_last_r <= '0;
      rd_idx_r  <= '0;
      rd_data_r <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (state_r[p])
          IDLE: begin
            if (bus.scan_start[p] && (first_of(p) <= last_of(p)) && in_range(last_of(p))) begin
              state_r[p]    <= RUN;
              busy_r[p]     <= 1'b1;
              valid_r[p]    <= 1'b1;
              err_r[p]      <= 1'b0;
              last_idx_r[p] <= last_of(p);
              rd_idx_r[p*ADDR_WIDTH +: ADDR_WIDTH]  <= first_of(p);
              rd_data_r[p*DATA_WIDTH +: DATA_WIDTH] <= fetch(first_of(p));
              rd_last_r[p]  <= (first_of(p) == last_of(p));
            end else begin
              err_r[p] <= bus.scan_start[p];
            end
          end
          RUN: begin
            err_r[p] <= 1'b0;
            // Abort outranks accept; an accepted last beat also ends the scan.
            if (bus.scan_abort[p] || (bus.rd_ready[p] && rd_last_r[p])) begin
              state_r[p]   <= IDLE;
              busy_r[p]    <= 1'b0;
              valid_r[p]   <= 1'b0;
              rd_last_r[p] <= 1'b0;
            end else if (bus.rd_ready[p]) begin
              rd_idx_r[p*ADDR_WIDTH +: ADDR_WIDTH]  <= next_of(p);
              rd_data_r[p*DATA_WIDTH +: DATA_WIDTH] <= fetch(next_of(p));
              rd_last_r[p] <= (next_of(p) == last_idx_r[p]);
            end
          end
          default: begin
            state_r[p]   <= IDLE;
            busy_r[p]    <= 1'b0;
            valid_r[p]   <= 1'b0;
            err_r[p]     <= 1'b0;
            rd_last_r[p] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.err      = err_r;
  assign bus.rd_valid = valid_r;
  assign bus.rd_last  = rd_last_r;
  assign bus.rd_idx   = rd_idx_r;
  assign bus.rd_data  = rd_data_r;
endmodule
